// File: rtl/edge_detect_mc.sv
// Multi-channel edge detector: synchronizer, optional glitch filter, edge pulses, sticky flags
// and saturating per-channel event counters. Filter compiled in by EDGE_GLITCH_FILTER_EN.
module edge_detect_mc #(
  parameter int unsigned CH          = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYC    = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH-1:0]         din,
  input  logic [2*CH-1:0]       mode,
  input  logic [CH-1:0]         clr,
  output logic [CH-1:0]         level,
  output logic [CH-1:0]         edge_pulse,
  output logic [CH-1:0]         edge_dir,
  output logic                  any_edge,
  output logic [CH-1:0]         evt_flag,
  output logic [CH*CNT_W-1:0]   evt_cnt
);

  if (CH < 1 || CH > 32 || SYNC_STAGES < 2 || FILT_CYC < 1 || CNT_W < 1) begin : g_bad_params
    $error("edge_detect_mc: parameter out of range");
  end

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [CH-1:0] sync_q [SYNC_STAGES];
  logic [CH-1:0] sync_out;
  logic [CH-1:0] level_q, level_d;
  logic [CH-1:0] prev_q;
  logic [CH-1:0] rise, fall;
  logic [CH-1:0] mode_rise, mode_fall;
  logic [CH-1:0] pulse_q, pulse_d;
  logic [CH-1:0] dir_q, dir_d;
  logic [CH-1:0] flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q [CH];
  logic [CNT_W-1:0] cnt_d [CH];

  // Synchronizer presets to 1 so an already-high input does not look like a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '1;
    end else begin
      sync_q[0] <= din;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef EDGE_GLITCH_FILTER_EN
  localparam int unsigned FW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
  localparam logic [FW-1:0] FiltLast = FW'(FILT_CYC - 1);

  logic [FW-1:0] filt_q [CH];
  logic [FW-1:0] filt_d [CH];

  // Level follows sync_out only after it has differed for FILT_CYC consecutive samples.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < CH; i++) begin
      filt_d[i] = '0;
      if (sync_out[i] != level_q[i]) begin
        if (filt_q[i] == FiltLast) begin
          level_d[i] = sync_out[i];
        end else begin
          filt_d[i] = filt_q[i] + FW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) filt_q[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++) filt_q[i] <= filt_d[i];
    end
  end
`else
  assign level_d = sync_out;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '1;
      prev_q  <= '1;
    end else begin
      level_q <= level_d;
      prev_q  <= level_q;
    end
  end

  always_comb begin
    mode_rise = '0;
    mode_fall = '0;
    for (int i = 0; i < CH; i++) begin
      mode_rise[i] = mode[2*i];
      mode_fall[i] = mode[2*i+1];
    end
  end

  assign rise    = level_q & ~prev_q;
  assign fall    = ~level_q & prev_q;
  assign pulse_d = (rise & mode_rise) | (fall & mode_fall);

  always_comb begin
    dir_d = dir_q;
    for (int i = 0; i < CH; i++) begin
      if (pulse_d[i]) dir_d[i] = rise[i];
    end
  end

  // A clear coinciding with a pulse keeps that event: flag=1, count=1.
  always_comb begin
    flag_d = flag_q;
    for (int i = 0; i < CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr[i]) begin
        flag_d[i] = pulse_q[i];
        cnt_d[i]  = pulse_q[i] ? CNT_W'(1) : '0;
      end else if (pulse_q[i]) begin
        flag_d[i] = 1'b1;
        if (cnt_q[i] != CntMax) cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_q <= '0;
      dir_q   <= '0;
      flag_q  <= '0;
      for (int i = 0; i < CH; i++) cnt_q[i] <= '0;
    end else begin
      pulse_q <= pulse_d;
      dir_q   <= dir_d;
      flag_q  <= flag_d;
      for (int i = 0; i < CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_cnt_out
    assign evt_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  assign level      = level_q;
  assign edge_pulse = pulse_q;
  assign edge_dir   = dir_q;
  assign any_edge   = |pulse_q;
  assign evt_flag   = flag_q;

endmodule

// File: tb/tb_edge_detect_mc.sv
// Directed bench for edge_detect_mc: default 4-channel instance plus a CNT_W=2 instance for
// saturation and clear/pulse collision. Expected latencies follow EDGE_GLITCH_FILTER_EN.
module tb_edge_detect_mc;

`ifdef EDGE_GLITCH_FILTER_EN
  localparam int Lat          = 7;
  localparam int GlitchPulses = 0;
`else
  localparam int Lat          = 4;
  localparam int GlitchPulses = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  din_a, clr_a, level_a, pulse_a, dir_a, flag_a;
  logic [7:0]  mode_a;
  logic        any_a;
  logic [63:0] cnt_a;
  logic [0:0]  din_b, clr_b, level_b, pulse_b, dir_b, flag_b;
  logic [1:0]  mode_b;
  logic        any_b;
  logic [1:0]  cnt_b;

  int checks = 0;
  int failures = 0;
  int n, first, anyn;
  logic d;

  edge_detect_mc u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din_a),
    .mode       (mode_a),
    .clr        (clr_a),
    .level      (level_a),
    .edge_pulse (pulse_a),
    .edge_dir   (dir_a),
    .any_edge   (any_a),
    .evt_flag   (flag_a),
    .evt_cnt    (cnt_a)
  );

  edge_detect_mc #(.CH(1), .CNT_W(2)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din_b),
    .mode       (mode_b),
    .clr        (clr_b),
    .level      (level_b),
    .edge_pulse (pulse_b),
    .edge_dir   (dir_b),
    .any_edge   (any_b),
    .evt_flag   (flag_b),
    .evt_cnt    (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs n cycles on DUT A, counting pulses on channel ch; flips din[ch] after step flip_at.
  task automatic watch(input int ch, input int cycles, input int flip_at, output int cnt,
                       output int first_k, output logic dir, output int any_cnt);
    cnt = 0;
    first_k = -1;
    dir = 1'bx;
    any_cnt = 0;
    for (int k = 1; k <= cycles; k++) begin
      step();
      if (pulse_a[ch]) begin
        cnt++;
        if (first_k < 0) begin
          first_k = k;
          dir = dir_a[ch];
        end
      end
      if (any_a) any_cnt++;
      if (k == flip_at) din_a[ch] = ~din_a[ch];
    end
  endtask

  initial begin
    rst_n = 1'b0;
    din_a = 4'hF; mode_a = 8'hFF; clr_a = 4'h0;
    din_b = 1'b0; mode_b = 2'b01; clr_b = 1'b0;
    step(); step();
    chk("rst_level", level_a, 4'hF);
    chk("rst_pulse", pulse_a, 4'h0);
    chk("rst_dir", dir_a, 4'h0);
    chk("rst_any", any_a, 1'b0);
    chk("rst_flag", flag_a, 4'h0);
    chk("rst_cnt", cnt_a, 64'h0);
    rst_n = 1'b1;
    watch(0, 20, 0, n, first, d, anyn);
    chk("high_after_rst_no_edge", anyn, 0);
    chk("high_after_rst_flag", flag_a, 4'h0);

    // Channel 2 held low through reset, fall-only mode.
    rst_n = 1'b0; din_a = 4'b1011; mode_a = 8'h20;
    step(); step();
    rst_n = 1'b1;
    watch(2, 12, 0, n, first, d, anyn);
    chk("fall_rst_count", n, 1);
    chk("fall_rst_latency", first, Lat);
    chk("fall_rst_dir", d, 1'b0);
    chk("fall_rst_flag", flag_a, 4'b0100);
    chk("fall_rst_cnt2", cnt_a[2*16 +: 16], 16'd1);

    // Mode off: level tracks, nothing else moves.
    mode_a = 8'h00; din_a = 4'b0000;
    watch(0, 12, 0, n, first, d, anyn);
    chk("off_no_pulse", anyn, 0);
    chk("off_level", level_a, 4'h0);
    chk("off_flag", flag_a, 4'b0100);
    chk("off_cnt2", cnt_a[2*16 +: 16], 16'd1);

    clr_a = 4'hF; step(); clr_a = 4'h0;
    chk("clr_flag", flag_a, 4'h0);
    chk("clr_cnt", cnt_a, 64'h0);

    // Channel 0 rise-only.
    mode_a = 8'h01; din_a[0] = 1'b1;
    watch(0, 12, 0, n, first, d, anyn);
    chk("rise0_count", n, 1);
    chk("rise0_latency", first, Lat);
    chk("rise0_dir", d, 1'b1);
    chk("rise0_cnt", cnt_a[0 +: 16], 16'd1);

    // Channel 1: both edges, then rise-only.
    din_a[1] = 1'b1;
    repeat (12) step();
    mode_a = 8'h0D; din_a[1] = 1'b0;
    watch(1, 10, 0, n, first, d, anyn);
    chk("both1_fall_count", n, 1);
    chk("both1_fall_dir", d, 1'b0);
    din_a[1] = 1'b1;
    watch(1, 10, 0, n, first, d, anyn);
    chk("both1_rise_count", n, 1);
    chk("both1_rise_dir", d, 1'b1);
    chk("both1_cnt", cnt_a[1*16 +: 16], 16'd2);
    mode_a = 8'h05; din_a[1] = 1'b0;
    watch(1, 10, 0, n, first, d, anyn);
    chk("rise1_fall_ignored", n, 0);
    din_a[1] = 1'b1;
    watch(1, 10, 0, n, first, d, anyn);
    chk("rise1_rise_count", n, 1);
    chk("rise1_cnt", cnt_a[1*16 +: 16], 16'd3);

    // All channels toggle together.
    mode_a = 8'hFF; din_a = ~din_a;
    repeat (Lat - 1) step();
    chk("all_pre_pulse", pulse_a, 4'h0);
    step();
    chk("all_pulse", pulse_a, 4'hF);
    chk("all_any", any_a, 1'b1);
    chk("all_dir", dir_a, 4'b1100);
    step();
    chk("all_post_pulse", pulse_a, 4'h0);
    chk("all_post_any", any_a, 1'b0);
    repeat (10) step();

    // Reset during a pulse, then ch2/ch3 held low produce one fall detection.
    din_a = ~din_a;
    repeat (Lat) step();
    chk("midrst_pulse_before", pulse_a, 4'hF);
    rst_n = 1'b0;
    #1;
    chk("midrst_pulse_abort", pulse_a, 4'h0);
    chk("midrst_any_abort", any_a, 1'b0);
    chk("midrst_cnt", cnt_a, 64'h0);
    step();
    rst_n = 1'b1;
    watch(2, 12, 0, n, first, d, anyn);
    chk("midrst_fall_count", n, 1);
    chk("midrst_fall_latency", first, Lat);
    chk("midrst_fall_dir", d, 1'b0);
    chk("midrst_any_cycles", anyn, 1);

    // Glitch filter behaviour on channel 0.
    mode_a = 8'h01; din_a[0] = 1'b0;
    repeat (12) step();
    din_a[0] = 1'b1;
    watch(0, 16, 3, n, first, d, anyn);
    chk("glitch3_count", n, GlitchPulses);
    chk("glitch3_level", level_a[0], 1'b0);
    din_a[0] = 1'b1;
    watch(0, 16, 4, n, first, d, anyn);
    chk("hold4_count", n, 1);
    chk("hold4_latency", first, Lat);
    chk("hold4_dir", d, 1'b1);

    // Saturating 2-bit counter.
    for (int k = 1; k <= 5; k++) begin
      din_b = 1'b1;
      repeat (10) step();
      din_b = 1'b0;
      repeat (10) step();
      chk($sformatf("sat_cnt_%0d", k), cnt_b, (k < 3) ? k : 3);
    end
    chk("sat_flag", flag_b, 1'b1);
    din_b = 1'b1;
    repeat (Lat) step();
    chk("coll_pulse", pulse_b, 1'b1);
    clr_b = 1'b1; step(); clr_b = 1'b0;
    chk("coll_cnt", cnt_b, 2'd1);
    chk("coll_flag", flag_b, 1'b1);
    repeat (10) step();
    clr_b = 1'b1; step(); clr_b = 1'b0;
    chk("clr_b_cnt", cnt_b, 2'd0);
    chk("clr_b_flag", flag_b, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
